// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight and
// buffers returned words with their PCs for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_outstanding;
    logic          r_discard;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_buf_data [BUF_DEPTH];
    logic [31:0]   r_buf_pc   [BUF_DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_req_fire;
    logic [CW:0]   w_occ;

    assign w_pop  = inst_valid & inst_ready;
    assign w_push = imem_rsp_valid & ~r_discard & ~redirect_valid;

    // Occupancy the buffer will have once the in-flight word lands; the new
    // request only goes out if its response is guaranteed a free slot.
    assign w_occ = {1'b0, r_count} + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);

    assign imem_req_valid = rst_n & ~redirect_valid
                          & (~r_outstanding | imem_rsp_valid)
                          & (w_occ < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign inst_valid = rst_n & (r_count != '0);
    assign inst_data  = inst_valid ? r_buf_data[r_head] : 32'h0;
    assign inst_pc    = inst_valid ? r_buf_pc[r_head]   : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_req_pc      <= 32'h0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else begin
            if (w_req_fire)
                r_outstanding <= 1'b1;
            else if (imem_rsp_valid)
                r_outstanding <= 1'b0;

            // A redirect with the word still in flight poisons that word.
            if (imem_rsp_valid)
                r_discard <= 1'b0;
            else if (redirect_valid && r_outstanding)
                r_discard <= 1'b1;

            if (redirect_valid) begin
                r_pc    <= {redirect_pc[31:2], 2'b00};
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc     <= r_pc + 32'd4;
                    r_req_pc <= r_pc;
                end
                if (w_push)
                    r_tail <= r_tail + 1'b1;
                if (w_pop)
                    r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_buf_data[r_tail] <= imem_rsp_data;
            r_buf_pc[r_tail]   <= r_req_pc;
        end
    end

endmodule
